// File: rtl/cpu_pkg.sv
// Shared types and defaults for the program-counter / branch-control stage.
package cpu_pkg;

  localparam int PC_W      = 10;
  localparam int LUT_N     = 32;
  localparam int LUT_IDX_W = $clog2(LUT_N);

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_jump_lut.sv
// Branch-target table: synchronous write and reset-to-zero, combinational read.
module jump_lut
  import cpu_pkg::*;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int LUT_N = cpu_pkg::LUT_N,
  parameter int IDX_W = $clog2(LUT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [PC_W-1:0]  wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [PC_W-1:0]  rdata
);

  logic [PC_W-1:0] mem_r [LUT_N];

  // Table storage: cleared by reset, written one entry per edge when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LUT_N; i++) begin
        mem_r[i] <= {PC_W{1'b0}};
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Jump target lookup.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter with run/halt sequencing and LUT-based jumps driven by decoder controls.
module pc_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W  = cpu_pkg::PC_W,
  parameter int LUT_N = cpu_pkg::LUT_N,
  parameter int IDX_W = $clog2(LUT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             alu_flag,
  input  logic             flag_we,
  input  logic             branch_en,
  input  logic             jump_en,
  input  logic [IDX_W-1:0] target_idx,
  input  logic             halt,
  input  logic             lut_we,
  input  logic [IDX_W-1:0] lut_addr,
  input  logic [PC_W-1:0]  lut_data,
  output logic [PC_W-1:0]  pc,
  output logic             flag_q,
  output logic             running,
  output logic             done
);

  pc_state_t       state_r;
  pc_state_t       state_nxt_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic            flag_r;
  logic            flag_nxt_s;
  logic            running_r;
  logic            done_r;
  logic            lut_we_s;
  logic [PC_W-1:0] target_s;

  // The table is frozen once a program is executing.
  always_comb begin
    lut_we_s = lut_we & (state_r == IDLE);
  end

  jump_lut #(
    .PC_W  (PC_W),
    .LUT_N (LUT_N),
    .IDX_W (IDX_W)
  ) u_jump_lut (
    .clk   (clk),
    .reset (reset),
    .we    (lut_we_s),
    .waddr (lut_addr),
    .wdata (lut_data),
    .raddr (target_idx),
    .rdata (target_s)
  );

  // Next-state, next-pc and next-flag selection.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    flag_nxt_s  = flag_r;
    case (state_r)
      IDLE: begin
        pc_nxt_s   = {PC_W{1'b0}};
        flag_nxt_s = 1'b0;
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        // Branch decision uses the flag registered before this edge.
        if (flag_we) begin
          flag_nxt_s = alu_flag;
        end else begin
          flag_nxt_s = flag_r;
        end
        if (halt) begin
          state_nxt_s = HALTED;
          pc_nxt_s    = pc_r;
        end else if (jump_en) begin
          pc_nxt_s = target_s;
        end else if (branch_en && flag_r) begin
          pc_nxt_s = target_s;
        end else begin
          pc_nxt_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
      end
      HALTED: begin
        if (start) begin
          state_nxt_s = RUN;
          pc_nxt_s    = {PC_W{1'b0}};
          flag_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = {PC_W{1'b0}};
        flag_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pc, flag and status registers; status bits decode the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pc_r      <= {PC_W{1'b0}};
      flag_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pc_r      <= pc_nxt_s;
      flag_r    <= flag_nxt_s;
      running_r <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == HALTED);
    end
  end

  // Output drive.
  always_comb begin
    pc      = pc_r;
    flag_q  = flag_r;
    running = running_r;
    done    = done_r;
  end

endmodule
